// File: rtl/order_book_array.sv
// Multi-stock order-book engine: N_STOCKS books of DEPTH resting orders with
// add / cancel / modify and a registered highest-price best order per book.
module order_book_array #(
   parameter int N_STOCKS = 4,
   parameter int DEPTH    = 8,
   parameter int ID_W     = 32,
   parameter int QTY_W    = 32,
   parameter int PRICE_W  = 64,
   localparam int SW = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1,
   localparam int IW = $clog2(DEPTH)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [SW-1:0]               in_stock,
   input  logic [1:0]                  in_op,
   input  logic [ID_W-1:0]             in_order_id,
   input  logic [QTY_W-1:0]            in_quantity,
   input  logic [PRICE_W-1:0]          in_price,
   output logic                        resp_valid,
   output logic [1:0]                  resp_status,
   output logic [ID_W-1:0]             resp_order_id,
   output logic [N_STOCKS-1:0]         best_valid,
   output logic [N_STOCKS*ID_W-1:0]    best_order_id,
   output logic [N_STOCKS*QTY_W-1:0]   best_quantity,
   output logic [N_STOCKS*PRICE_W-1:0] best_price,
   output logic                        busy
);

   // Handshake: a request transfers on a rising edge where in_valid && in_ready;
   // in_ready is high only in IDLE, and inputs are ignored in every other state.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESCAN = 2'd2} state_t;

   localparam logic [1:0] OP_ADD       = 2'b01;
   localparam logic [1:0] OP_CANCEL    = 2'b10;
   localparam logic [1:0] OP_MODIFY    = 2'b11;
   localparam logic [1:0] ST_OK        = 2'b00;
   localparam logic [1:0] ST_FULL      = 2'b01;
   localparam logic [1:0] ST_NOT_FOUND = 2'b10;
   localparam logic [1:0] ST_BAD_STOCK = 2'b11;

   state_t               state_q, state_d;
   logic [SW-1:0]        req_stock_q, req_stock_d;
   logic [1:0]           req_op_q, req_op_d;
   logic [ID_W-1:0]      req_id_q, req_id_d;
   logic [QTY_W-1:0]     req_qty_q, req_qty_d;
   logic [PRICE_W-1:0]   req_price_q, req_price_d;

   logic [DEPTH-1:0]     slot_valid_q [N_STOCKS];
   logic [DEPTH-1:0]     slot_valid_d [N_STOCKS];
   logic [ID_W-1:0]      slot_id_q    [N_STOCKS][DEPTH];
   logic [ID_W-1:0]      slot_id_d    [N_STOCKS][DEPTH];
   logic [QTY_W-1:0]     slot_qty_q   [N_STOCKS][DEPTH];
   logic [QTY_W-1:0]     slot_qty_d   [N_STOCKS][DEPTH];
   logic [PRICE_W-1:0]   slot_price_q [N_STOCKS][DEPTH];
   logic [PRICE_W-1:0]   slot_price_d [N_STOCKS][DEPTH];

   logic [N_STOCKS-1:0]  best_valid_q, best_valid_d;
   logic [IW-1:0]        best_idx_q   [N_STOCKS];
   logic [IW-1:0]        best_idx_d   [N_STOCKS];
   logic [ID_W-1:0]      best_id_q    [N_STOCKS];
   logic [ID_W-1:0]      best_id_d    [N_STOCKS];
   logic [QTY_W-1:0]     best_qty_q   [N_STOCKS];
   logic [QTY_W-1:0]     best_qty_d   [N_STOCKS];
   logic [PRICE_W-1:0]   best_price_q [N_STOCKS];
   logic [PRICE_W-1:0]   best_price_d [N_STOCKS];

   logic [IW-1:0]        scan_cnt_q, scan_cnt_d;
   logic [IW-1:0]        scan_idx_q, scan_idx_d;
   logic                 scan_found_q, scan_found_d;
   logic [PRICE_W-1:0]   scan_max_q, scan_max_d;

   logic                 resp_valid_q, resp_valid_d;
   logic [1:0]           resp_status_q, resp_status_d;
   logic [ID_W-1:0]      resp_id_q, resp_id_d;

   // View of the addressed book and the lookups performed on it
   logic                 stock_ok;
   logic [DEPTH-1:0]     bk_valid;
   logic [ID_W-1:0]      bk_id    [DEPTH];
   logic [QTY_W-1:0]     bk_qty   [DEPTH];
   logic [PRICE_W-1:0]   bk_price [DEPTH];
   logic                 cur_bvalid;
   logic [IW-1:0]        cur_bidx;
   logic [PRICE_W-1:0]   cur_bprice;
   logic                 free_found, match_found;
   logic [IW-1:0]        free_idx, match_idx;
   logic                 scan_take, scan_hit;
   logic [IW-1:0]        scan_sel;

   logic                 wr_add, wr_qty, wr_clear;
   logic                 best_add, best_qty_upd, best_drop, best_commit;

   always_comb begin
      stock_ok   = ({1'b0, req_stock_q} < (SW+1)'(N_STOCKS));
      bk_valid   = '0;
      bk_id      = '{default: '0};
      bk_qty     = '{default: '0};
      bk_price   = '{default: '0};
      cur_bvalid = 1'b0;
      cur_bidx   = '0;
      cur_bprice = '0;
      for (int s = 0; s < N_STOCKS; s++) begin
         if (req_stock_q == SW'(s)) begin
            bk_valid   = slot_valid_q[s];
            bk_id      = slot_id_q[s];
            bk_qty     = slot_qty_q[s];
            bk_price   = slot_price_q[s];
            cur_bvalid = best_valid_q[s];
            cur_bidx   = best_idx_q[s];
            cur_bprice = best_price_q[s];
         end
      end
      // Descending walk so the lowest matching index is the one left standing
      free_found  = 1'b0;
      free_idx    = '0;
      match_found = 1'b0;
      match_idx   = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (!bk_valid[k]) begin
            free_found = 1'b1;
            free_idx   = IW'(k);
         end
         if (bk_valid[k] && (bk_id[k] == req_id_q)) begin
            match_found = 1'b1;
            match_idx   = IW'(k);
         end
      end
      // Strict greater-than keeps the earlier slot on equal prices
      scan_take = bk_valid[scan_cnt_q] &&
                  (!scan_found_q || (bk_price[scan_cnt_q] > scan_max_q));
      scan_hit  = scan_found_q || scan_take;
      scan_sel  = scan_take ? scan_cnt_q : scan_idx_q;
   end

   always_comb begin
      state_d       = state_q;
      req_stock_d   = req_stock_q;
      req_op_d      = req_op_q;
      req_id_d      = req_id_q;
      req_qty_d     = req_qty_q;
      req_price_d   = req_price_q;
      scan_cnt_d    = scan_cnt_q;
      scan_idx_d    = scan_idx_q;
      scan_found_d  = scan_found_q;
      scan_max_d    = scan_max_q;
      resp_valid_d  = 1'b0;
      resp_status_d = resp_status_q;
      resp_id_d     = resp_id_q;
      wr_add        = 1'b0;
      wr_qty        = 1'b0;
      wr_clear      = 1'b0;
      best_add      = 1'b0;
      best_qty_upd  = 1'b0;
      best_drop     = 1'b0;
      best_commit   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               req_stock_d = in_stock;
               req_op_d    = in_op;
               req_id_d    = in_order_id;
               req_qty_d   = in_quantity;
               req_price_d = in_price;
               state_d     = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d       = S_IDLE;
            resp_valid_d  = 1'b1;
            resp_status_d = ST_OK;
            resp_id_d     = req_id_q;
            if (!stock_ok) begin
               resp_status_d = ST_BAD_STOCK;
            end else if (req_op_q == OP_ADD) begin
               if (!free_found) begin
                  resp_status_d = ST_FULL;
               end else begin
                  wr_add   = 1'b1;
                  best_add = !cur_bvalid || (req_price_q > cur_bprice);
               end
            end else if ((req_op_q == OP_CANCEL) || (req_op_q == OP_MODIFY)) begin
               if (!match_found) begin
                  resp_status_d = ST_NOT_FOUND;
               end else if ((req_op_q == OP_MODIFY) && (req_qty_q != '0)) begin
                  wr_qty       = 1'b1;
                  best_qty_upd = cur_bvalid && (cur_bidx == match_idx);
               end else begin
                  wr_clear = 1'b1;
                  if (cur_bvalid && (cur_bidx == match_idx)) begin
                     best_drop    = 1'b1;
                     resp_valid_d = 1'b0;
                     state_d      = S_RESCAN;
                     scan_cnt_d   = '0;
                     scan_idx_d   = '0;
                     scan_found_d = 1'b0;
                     scan_max_d   = '0;
                  end
               end
            end
         end
         S_RESCAN: begin
            if (scan_take) begin
               scan_found_d = 1'b1;
               scan_idx_d   = scan_cnt_q;
               scan_max_d   = bk_price[scan_cnt_q];
            end
            scan_cnt_d = scan_cnt_q + 1'b1;
            if (scan_cnt_q == IW'(DEPTH - 1)) begin
               best_commit   = 1'b1;
               resp_valid_d  = 1'b1;
               resp_status_d = ST_OK;
               state_d       = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      slot_valid_d = slot_valid_q;
      slot_id_d    = slot_id_q;
      slot_qty_d   = slot_qty_q;
      slot_price_d = slot_price_q;
      best_valid_d = best_valid_q;
      best_idx_d   = best_idx_q;
      best_id_d    = best_id_q;
      best_qty_d   = best_qty_q;
      best_price_d = best_price_q;
      for (int s = 0; s < N_STOCKS; s++) begin
         if (stock_ok && (req_stock_q == SW'(s))) begin
            if (wr_add) begin
               slot_valid_d[s][free_idx] = 1'b1;
               slot_id_d[s][free_idx]    = req_id_q;
               slot_qty_d[s][free_idx]   = req_qty_q;
               slot_price_d[s][free_idx] = req_price_q;
            end
            if (best_add) begin
               best_valid_d[s] = 1'b1;
               best_idx_d[s]   = free_idx;
               best_id_d[s]    = req_id_q;
               best_qty_d[s]   = req_qty_q;
               best_price_d[s] = req_price_q;
            end
            if (wr_qty)       slot_qty_d[s][match_idx]   = req_qty_q;
            if (best_qty_upd) best_qty_d[s]              = req_qty_q;
            if (wr_clear)     slot_valid_d[s][match_idx] = 1'b0;
            if (best_drop)    best_valid_d[s]            = 1'b0;
            if (best_commit) begin
               best_valid_d[s] = scan_hit;
               best_idx_d[s]   = scan_hit ? scan_sel : '0;
               best_id_d[s]    = scan_hit ? bk_id[scan_sel] : '0;
               best_qty_d[s]   = scan_hit ? bk_qty[scan_sel] : '0;
               best_price_d[s] = scan_hit ? bk_price[scan_sel] : '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         req_stock_q   <= '0;
         req_op_q      <= '0;
         req_id_q      <= '0;
         req_qty_q     <= '0;
         req_price_q   <= '0;
         best_valid_q  <= '0;
         scan_cnt_q    <= '0;
         scan_idx_q    <= '0;
         scan_found_q  <= 1'b0;
         scan_max_q    <= '0;
         resp_valid_q  <= 1'b0;
         resp_status_q <= '0;
         resp_id_q     <= '0;
         for (int s = 0; s < N_STOCKS; s++) begin
            slot_valid_q[s] <= '0;
            best_idx_q[s]   <= '0;
            best_id_q[s]    <= '0;
            best_qty_q[s]   <= '0;
            best_price_q[s] <= '0;
            for (int k = 0; k < DEPTH; k++) begin
               slot_id_q[s][k]    <= '0;
               slot_qty_q[s][k]   <= '0;
               slot_price_q[s][k] <= '0;
            end
         end
      end else begin
         state_q       <= state_d;
         req_stock_q   <= req_stock_d;
         req_op_q      <= req_op_d;
         req_id_q      <= req_id_d;
         req_qty_q     <= req_qty_d;
         req_price_q   <= req_price_d;
         slot_valid_q  <= slot_valid_d;
         slot_id_q     <= slot_id_d;
         slot_qty_q    <= slot_qty_d;
         slot_price_q  <= slot_price_d;
         best_valid_q  <= best_valid_d;
         best_idx_q    <= best_idx_d;
         best_id_q     <= best_id_d;
         best_qty_q    <= best_qty_d;
         best_price_q  <= best_price_d;
         scan_cnt_q    <= scan_cnt_d;
         scan_idx_q    <= scan_idx_d;
         scan_found_q  <= scan_found_d;
         scan_max_q    <= scan_max_d;
         resp_valid_q  <= resp_valid_d;
         resp_status_q <= resp_status_d;
         resp_id_q     <= resp_id_d;
      end
   end

   assign in_ready      = (state_q == S_IDLE);
   assign busy          = ~in_ready;
   assign resp_valid    = resp_valid_q;
   assign resp_status   = resp_status_q;
   assign resp_order_id = resp_id_q;
   assign best_valid    = best_valid_q;

   for (genvar g = 0; g < N_STOCKS; g++) begin : g_pack
      assign best_order_id[g*ID_W +: ID_W]      = best_id_q[g];
      assign best_quantity[g*QTY_W +: QTY_W]    = best_qty_q[g];
      assign best_price[g*PRICE_W +: PRICE_W]   = best_price_q[g];
   end

endmodule

// File: doc/order_book_array.md
# order_book_array

Parametrised multi-stock order-book engine that replaces the fixed four-instance book structure with a single block. It holds `N_STOCKS` books of `DEPTH` resting orders each, in one storage array. It accepts parsed orders over a valid/ready handshake and supports add, cancel and quantity-modify operations. It maintains a registered best (highest-price) order per stock, rescanning the book when the best order is cancelled. It sits directly downstream of the parser and drives the per-stock best-order outputs.

## Interface
- `N_STOCKS`, 4: number of books (1..16).
- `DEPTH`, 8: order slots per book (2..32).
- `ID_W`, 32: order-id width.
- `QTY_W`, 32: quantity width.
- `PRICE_W`, 64: price width, unsigned.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears everything.
- `in_valid` in 1: request present.
- `in_ready` out 1: block can accept; high only in IDLE.
- `in_stock` in `$clog2(N_STOCKS)` (min 1): target book.
- `in_op` in 2: 00 NOP, 01 ADD, 10 CANCEL, 11 MODIFY.
- `in_order_id` in `ID_W`: order id.
- `in_quantity` in `QTY_W`: quantity (ADD/MODIFY).
- `in_price` in `PRICE_W`: price (ADD only).
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_status` out 2: 00 OK, 01 FULL, 10 NOT_FOUND, 11 BAD_STOCK.
- `resp_order_id` out `ID_W`: echo of the completed request id.
- `best_valid` out `N_STOCKS`: book s has a best order.
- `best_order_id` out `N_STOCKS*ID_W`: per-stock best id, stock s at `[s*ID_W +: ID_W]`.
- `best_quantity` out `N_STOCKS*QTY_W`: per-stock best quantity, packed the same way.
- `best_price` out `N_STOCKS*PRICE_W`: per-stock best price, packed the same way.
- `busy` out 1: equals `!in_ready`.

## Operation
- Per slot: valid bit, id, quantity, price. Per stock: best index plus registered best outputs.
- **FSM states:** IDLE, EXEC, RESCAN.
- **IDLE:** `in_ready`=1. When `in_valid` is high, latch the request and go to EXEC.
- **EXEC, bad stock:** `in_stock >= N_STOCKS` → BAD_STOCK, no state change.
- **EXEC, NOP:** OK, no change.
- **EXEC, ADD:** write to the lowest-index free slot of the book.
  - No free slot → FULL, book unchanged.
  - Best is updated if the book had no best, or if the new price is strictly greater than the current best price. Ties keep the existing best.
  - Duplicate ids are not checked.
- **EXEC, CANCEL/MODIFY lookup:** parallel compare of `in_order_id` against all valid slots of the book. The lowest-index match is used. No match → NOT_FOUND.
- **EXEC, MODIFY:**
  - Quantity 0 is executed as CANCEL.
  - Otherwise the slot quantity is overwritten. If the slot is the best, `best_quantity` is updated in the same commit. Status OK.
- **EXEC, CANCEL:**
  - Clear the slot valid bit.
  - If the slot is not the best → OK, return to IDLE.
  - If the slot is the best → clear `best_valid[s]` and go to RESCAN.
- **RESCAN:** examine slot 0..DEPTH-1 of the book, one per cycle.
  - A running max is tracked with strict greater-than, so the lowest index wins ties.
  - After slot DEPTH-1, commit the best outputs. `best_valid[s]`=1 iff any slot is valid; otherwise the outputs are zeroed.
  - Then pulse the response with status OK and return to IDLE.
- Books other than `in_stock` never change.
- Prices compare unsigned at full `PRICE_W`; no arithmetic wraps.

## Timing
- **Reset values:**
  - All slots invalid.
  - `best_valid`=0; `best_order_id`, `best_quantity`, `best_price`=0.
  - `resp_valid`=0, `resp_status`=0, `resp_order_id`=0.
  - FSM in IDLE, so `in_ready`=1 and `busy`=0 once reset is released.
- **Latency:** handshake at edge T; EXEC during cycle T+1.
  - Non-rescan ops: results and `resp_valid` visible in cycle T+2, with `in_ready`=1 in T+2.
  - Rescan ops: `resp_valid` and new best visible in cycle T+2+DEPTH.
- **Throughput:** one request per 2 cycles without rescan.
- `best_*` outputs change only at the commit edge that raises `resp_valid`.
  - Exception: a best-cancel drops `best_valid[s]` in T+2 and holds it low until the rescan commit.
- `in_*` inputs are ignored outside IDLE; the upstream holds them until `in_ready`.
- `resp_valid` is high for exactly one cycle per accepted request, never back-to-back.
- Reset asserted mid-EXEC or mid-RESCAN aborts the operation with no response.

## Test plan
- **Reset:** assert reset mid-RESCAN → all outputs 0, `in_ready`=1 next cycle, and a subsequent CANCEL returns NOT_FOUND.
- **ADD ordering:** ADD stock 1 ids 10/11/12 at prices 100/300/300 → `best_order_id[1]`=11, `best_price[1]`=300; other stocks have `best_valid`=0.
- **FULL:** DEPTH+1 ADDs to stock 0 → the last returns FULL with `resp_order_id` echoed and the best unchanged.
- **Best cancel and rescan:** after the ADD-ordering scenario, CANCEL id 11 → `best_valid[1]` low for DEPTH cycles, then best id 12, price 300. The response arrives exactly DEPTH+2 cycles after the handshake.
- **MODIFY:**
  - MODIFY id 12 quantity 7 → `best_quantity[1]`=7 in T+2.
  - MODIFY id 12 quantity 0 → behaves as a cancel and triggers a rescan, giving best id 10, price 100.
- **Error statuses:**
  - CANCEL an unknown id → NOT_FOUND.
  - With `N_STOCKS`=3, `in_stock`=3 → BAD_STOCK.
  - In both cases all books are unchanged.
